// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access sequencer
//
// Purpose:
//   Sequences single-port synchronous dmem accesses: word reads/writes,
//   sub-word load extraction (lb/lbu/lh/lhu/lw) and read-modify-write
//   merges for sb/sh. Stalls the pipeline until each access acks.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_i             access request, held until ack_o
//   instr_i[7:0]      one-hot op {sw,sh,sb,lw,lhu,lh,lbu,lb}
//   addr_i, wdata_i   byte address, store data
//   ack_o             one-cycle completion pulse
//   stall_o           req_i & ~ack_o
//   rdata_o, err_o    registered load result / error, valid with ack_o
//   dmem_*            memory port (en, we, word addr, wdata, rdata)
//
// Optional feature macro: DMEM_ALIGN_TRAP_EN (alignment trap on lh/lhu/sh/lw/sw)

module dmem_access_ctrl #(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [7:0]        instr_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ack_o,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              dmem_en_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic [31:0]       dmem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [7:0]        r_instr;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [2:0]        r_cnt;

  logic              w_legal;
  logic              w_misalign;
  logic              w_is_rmw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;
  logic              w_unused;

  // Address bits above the dmem word range are intentionally ignored.
  assign w_unused = &{1'b0, addr_i[31:ADDR_W+2]};

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign w_legal = (instr_i != 8'd0) && ((instr_i & (instr_i - 8'd1)) == 8'd0);

`ifdef DMEM_ALIGN_TRAP_EN
  assign w_misalign = ((instr_i[2] | instr_i[3] | instr_i[6]) & addr_i[0]) |
                      ((instr_i[4] | instr_i[7]) & (addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_is_rmw = r_instr[5] | r_instr[6];

  // Load extraction from the word returned by memory.
  assign w_byte = dmem_rdata_i[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    w_load = dmem_rdata_i;
    if (r_instr[0])      w_load = {{24{w_byte[7]}}, w_byte};
    else if (r_instr[1]) w_load = {24'd0, w_byte};
    else if (r_instr[2]) w_load = {{16{w_half[15]}}, w_half};
    else if (r_instr[3]) w_load = {16'd0, w_half};
  end

  // Read-modify-write merge: replace only the addressed lane.
  always_comb begin
    w_merge = dmem_rdata_i;
    if (r_instr[5])      w_merge[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
    else if (r_instr[6]) w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (!w_legal || w_misalign) w_next = S_DONE;
          else if (instr_i[7])        w_next = S_WRITE;
          else                        w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == 3'd1) w_next = w_is_rmw ? S_WRITE : S_DONE;
      end
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= 8'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_merge <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_instr <= instr_i;
            r_addr  <= addr_i[ADDR_W+1:0];
            r_wdata <= wdata_i;
            r_err   <= ~w_legal | w_misalign;
          end
        end
        S_READ: r_cnt <= 3'(RD_LAT);
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          // Memory data is valid only in the last countdown cycle.
          if (r_cnt == 3'd1) begin
            if (w_is_rmw) r_merge <= w_merge;
            else          r_rdata <= w_load;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port is a pure decode of state, so a WRITE cycle that coincides
  // with rst still presents the write to memory at that edge.
  assign dmem_en_o    = (r_state == S_READ) || (r_state == S_WRITE);
  assign dmem_we_o    = (r_state == S_WRITE);
  assign dmem_addr_o  = r_addr[ADDR_W+1:2];
  assign dmem_wdata_o = r_instr[7] ? r_wdata : r_merge;

  assign ack_o   = (r_state == S_DONE);
  assign stall_o = req_i & ~ack_o;
  assign rdata_o = r_rdata;
  assign err_o   = r_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl

module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, req_b;
  logic [7:0]  instr;
  logic [31:0] addr, wdata;

  logic        ack_a, stall_a, err_a, en_a, we_a;
  logic [31:0] rdata_a, mwdata_a, mrdata_a;
  logic [10:0] maddr_a;
  logic        ack_b, stall_b, err_b, en_b, we_b;
  logic [31:0] rdata_b, mwdata_b, mrdata_b;
  logic [10:0] maddr_b;

  dmem_access_ctrl #(.ADDR_W(11), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_i(req_a), .instr_i(instr), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack_a), .stall_o(stall_a), .rdata_o(rdata_a),
    .err_o(err_a), .dmem_en_o(en_a), .dmem_we_o(we_a), .dmem_addr_o(maddr_a),
    .dmem_wdata_o(mwdata_a), .dmem_rdata_i(mrdata_a)
  );

  dmem_access_ctrl #(.ADDR_W(11), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req_i(req_b), .instr_i(instr), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack_b), .stall_o(stall_b), .rdata_o(rdata_b),
    .err_o(err_b), .dmem_en_o(en_b), .dmem_we_o(we_b), .dmem_addr_o(maddr_b),
    .dmem_wdata_o(mwdata_b), .dmem_rdata_i(mrdata_b)
  );

  // Memory models: preload port, write/enable counters, fixed read latency.
  logic        pre_we = 1'b0;
  logic        pre_sel = 1'b0;
  logic [10:0] pre_addr = 11'd0;
  logic [31:0] pre_data = 32'd0;

  logic [31:0] mem_a [0:2047];
  logic [31:0] rd_a;
  int          wr_cnt_a, en_cnt_a;
  logic [31:0] last_wdata_a;
  logic [10:0] last_waddr_a;

  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem_a[pre_addr] <= pre_data;
    else if (en_a && we_a) begin
      mem_a[maddr_a] <= mwdata_a;
      last_wdata_a   <= mwdata_a;
      last_waddr_a   <= maddr_a;
      wr_cnt_a       <= wr_cnt_a + 1;
    end
    if (en_a) en_cnt_a <= en_cnt_a + 1;
    rd_a <= (en_a && !we_a) ? mem_a[maddr_a] : 32'hA5A5A5A5;
  end
  assign mrdata_a = rd_a;

  logic [31:0] mem_b [0:2047];
  logic [31:0] pipe_b [0:2];
  int          wr_cnt_b, en_cnt_b;
  logic [31:0] last_wdata_b;
  logic [10:0] last_waddr_b;

  always @(posedge clk) begin
    if (pre_we && pre_sel) mem_b[pre_addr] <= pre_data;
    else if (en_b && we_b) begin
      mem_b[maddr_b] <= mwdata_b;
      last_wdata_b   <= mwdata_b;
      last_waddr_b   <= maddr_b;
      wr_cnt_b       <= wr_cnt_b + 1;
    end
    if (en_b) en_cnt_b <= en_cnt_b + 1;
    pipe_b[0] <= (en_b && !we_b) ? mem_b[maddr_b] : 32'h5A5A5A5A;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mrdata_b = pipe_b[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input bit sel, input logic [10:0] wa, input logic [31:0] d);
    @(negedge clk);
    pre_sel = sel; pre_addr = wa; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Cycle 1 is the IDLE cycle where req first is high; cyc is the ack cycle.
  task automatic run(input bit sel, input logic [7:0] ins, input logic [31:0] ad,
                     input logic [31:0] wd, output int cyc, output int nstall,
                     output logic [31:0] rd, output logic er, output int nwr,
                     output int nen, output logic [31:0] ww, output logic [10:0] wa);
    int w0, e0;
    @(negedge clk);
    w0 = sel ? wr_cnt_b : wr_cnt_a;
    e0 = sel ? en_cnt_b : en_cnt_a;
    instr = ins; addr = ad; wdata = wd;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    cyc = 0; nstall = 0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (sel ? ack_b : ack_a) begin
        cyc = i;
        break;
      end
      if (sel ? stall_b : stall_a) nstall++;
      @(negedge clk);
    end
    rd = sel ? rdata_b : rdata_a;
    er = sel ? err_b : err_a;
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    nwr = (sel ? wr_cnt_b : wr_cnt_a) - w0;
    nen = (sel ? en_cnt_b : en_cnt_a) - e0;
    ww  = sel ? last_wdata_b : last_wdata_a;
    wa  = sel ? last_waddr_b : last_waddr_a;
  endtask

  typedef struct {
    bit          pre;
    logic [31:0] pre_val;
    logic [7:0]  ins;
    logic [31:0] ad;
    logic [31:0] wd;
    int          ack;
    logic [31:0] rd;
    logic        er;
    int          nwr;
    logic [31:0] ww;
    logic [10:0] wa;
    int          nen;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  int          cyc, nstall, nwr, nen;
  logic [31:0] rd, ww;
  logic [10:0] wa;
  logic        er;
  bit          seen_ack, seen_en;
  int          w0;

  initial begin
    //             pre   pre_val        ins    addr   wdata          ack rdata          err nwr wword          waddr nen
    vecs[0]  = '{1'b0, 32'h0,        8'h80, 32'h10, 32'hDEADBEEF, 3, 32'h00000000, 1'b0, 1, 32'hDEADBEEF, 11'd4, 1};
    vecs[1]  = '{1'b0, 32'h0,        8'h10, 32'h10, 32'h0,        4, 32'hDEADBEEF, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[2]  = '{1'b1, 32'h8899AABB, 8'h01, 32'h12, 32'h0,        4, 32'hFFFFFF99, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[3]  = '{1'b0, 32'h0,        8'h02, 32'h13, 32'h0,        4, 32'h00000088, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[4]  = '{1'b0, 32'h0,        8'h08, 32'h12, 32'h0,        4, 32'h00008899, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[5]  = '{1'b0, 32'h0,        8'h04, 32'h10, 32'h0,        4, 32'hFFFFAABB, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[6]  = '{1'b1, 32'h11223344, 8'h20, 32'h11, 32'h000000EE, 5, 32'hFFFFAABB, 1'b0, 1, 32'h1122EE44, 11'd4, 2};
    vecs[7]  = '{1'b0, 32'h0,        8'h10, 32'h10, 32'h0,        4, 32'h1122EE44, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[8]  = '{1'b1, 32'h11223344, 8'h40, 32'h12, 32'h0000CAFE, 5, 32'h1122EE44, 1'b0, 1, 32'hCAFE3344, 11'd4, 2};
    vecs[9]  = '{1'b0, 32'h0,        8'h10, 32'h10, 32'h0,        4, 32'hCAFE3344, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[10] = '{1'b0, 32'h0,        8'h00, 32'h10, 32'h0,        2, 32'hCAFE3344, 1'b1, 0, 32'h0,        11'd0, 0};
    vecs[11] = '{1'b0, 32'h0,        8'h30, 32'h10, 32'h0,        2, 32'hCAFE3344, 1'b1, 0, 32'h0,        11'd0, 0};
`ifdef DMEM_ALIGN_TRAP_EN
    vecs[12] = '{1'b1, 32'h55667788, 8'h10, 32'h11, 32'h0,        2, 32'hCAFE3344, 1'b1, 0, 32'h0,        11'd0, 0};
`else
    vecs[12] = '{1'b1, 32'h55667788, 8'h10, 32'h11, 32'h0,        4, 32'h55667788, 1'b0, 0, 32'h0,        11'd0, 1};
`endif
    vecs[13] = '{1'b0, 32'h0,        8'h01, 32'h13, 32'h0,        4, 32'h00000055, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[14] = '{1'b0, 32'h0,        8'h20, 32'h13, 32'h123456AB, 5, 32'h00000055, 1'b0, 1, 32'hAB667788, 11'd4, 2};
    vecs[15] = '{1'b0, 32'h0,        8'h04, 32'h12, 32'h0,        4, 32'hFFFFAB66, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[16] = '{1'b0, 32'h0,        8'h10, 32'h10, 32'h0,        4, 32'hAB667788, 1'b0, 0, 32'h0,        11'd0, 1};
    vecs[17] = '{1'b0, 32'h0,        8'h80, 32'h24, 32'h01020304, 3, 32'hAB667788, 1'b0, 1, 32'h01020304, 11'd9, 1};
    vecs[18] = '{1'b0, 32'h0,        8'h10, 32'h24, 32'h0,        4, 32'h01020304, 1'b0, 0, 32'h0,        11'd0, 1};

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    instr = 8'h00; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ack",   {31'd0, ack_a},   32'd0);
    chk("rst_err",   {31'd0, err_a},   32'd0);
    chk("rst_en",    {31'd0, en_a},    32'd0);
    chk("rst_we",    {31'd0, we_a},    32'd0);
    chk("rst_stall", {31'd0, stall_a}, 32'd0);
    chk("rst_rdata", rdata_a,          32'd0);
    chk("rst_rdata_b", rdata_b,        32'd0);

    for (int k = 0; k < NV; k++) begin
      if (vecs[k].pre) preload(1'b0, vecs[k].ad[12:2], vecs[k].pre_val);
      run(1'b0, vecs[k].ins, vecs[k].ad, vecs[k].wd, cyc, nstall, rd, er, nwr, nen, ww, wa);
      chk($sformatf("v%0d_ack_cycle", k), cyc, vecs[k].ack);
      chk($sformatf("v%0d_stall_cycles", k), nstall, vecs[k].ack - 1);
      chk($sformatf("v%0d_rdata", k), rd, vecs[k].rd);
      chk($sformatf("v%0d_err", k), {31'd0, er}, {31'd0, vecs[k].er});
      chk($sformatf("v%0d_writes", k), nwr, vecs[k].nwr);
      chk($sformatf("v%0d_enables", k), nen, vecs[k].nen);
      if (vecs[k].nwr > 0) begin
        chk($sformatf("v%0d_wword", k), ww, vecs[k].ww);
        chk($sformatf("v%0d_waddr", k), {21'd0, wa}, {21'd0, vecs[k].wa});
      end
    end

    // RD_LAT=3: sh merge and a load, each WAIT cycle adds one to latency.
    preload(1'b1, 11'd4, 32'h11223344);
    run(1'b1, 8'h40, 32'h12, 32'h0000CAFE, cyc, nstall, rd, er, nwr, nen, ww, wa);
    chk("lat3_sh_ack_cycle", cyc, 7);
    chk("lat3_sh_writes", nwr, 1);
    chk("lat3_sh_wword", ww, 32'hCAFE3344);
    chk("lat3_sh_enables", nen, 2);
    chk("lat3_sh_rdata", rd, 32'h0);
    run(1'b1, 8'h10, 32'h10, 32'h0, cyc, nstall, rd, er, nwr, nen, ww, wa);
    chk("lat3_lw_ack_cycle", cyc, 6);
    chk("lat3_lw_rdata", rd, 32'hCAFE3344);

    // Reset during the WAIT cycle of an sb: no write, no ack.
    preload(1'b0, 11'd4, 32'h11223344);
    @(negedge clk);
    w0 = wr_cnt_a;
    instr = 8'h20; addr = 32'h11; wdata = 32'h000000EE; req_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstmid_wait_en", {31'd0, en_a}, 32'd0);
    chk("rstmid_wait_stall", {31'd0, stall_a}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; req_a = 1'b0;
    seen_ack = 1'b0; seen_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_a) seen_ack = 1'b1;
      if (en_a)  seen_en  = 1'b1;
    end
    chk("rstmid_no_ack", {31'd0, seen_ack}, 32'd0);
    chk("rstmid_no_access", {31'd0, seen_en}, 32'd0);
    chk("rstmid_no_write", wr_cnt_a - w0, 32'd0);
    chk("rstmid_mem_intact", mem_a[4], 32'h11223344);
    chk("rstmid_rdata_cleared", rdata_a, 32'd0);
    run(1'b0, 8'h80, 32'h10, 32'h0BADF00D, cyc, nstall, rd, er, nwr, nen, ww, wa);
    chk("post_rst_sw_ack_cycle", cyc, 3);
    chk("post_rst_sw_writes", nwr, 1);
    chk("post_rst_sw_wword", ww, 32'h0BADF00D);
    chk("post_rst_sw_err", {31'd0, er}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences single-port synchronous data-memory accesses for the MEM stage of the static pipeline.
- Issues word reads and writes, and performs sub-word extraction for lb/lbu/lh/lhu/lw.
- Performs read-modify-write merges for sb/sh and direct writes for sw.
- Stalls the pipeline until each access completes.

Parameters:
- ADDR_W, 11, word-address width of dmem (dmem_addr_o = addr_i[ADDR_W+1:2]).
- RD_LAT, 1, dmem read latency in cycles (1..7); sizes the WAIT countdown counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  MEM-stage access request; held high with stable instr_i/addr_i/wdata_i until the ack_o cycle.
- instr_i  in  8  one-hot op: bit0 lb, bit1 lbu, bit2 lh, bit3 lhu, bit4 lw, bit5 sb, bit6 sh, bit7 sw.
- addr_i  in  32  byte address.
- wdata_i  in  32  register-file store data.
- ack_o  out  1  one-cycle completion pulse.
- stall_o  out  1  = req_i & ~ack_o (combinational); freezes the pipeline.
- rdata_o  out  32  registered load result; valid in the ack_o cycle and held until the next ack.
- err_o  out  1  registered; valid with ack_o.
- dmem_en_o  out  1  memory enable.
- dmem_we_o  out  1  memory write enable.
- dmem_addr_o  out  ADDR_W  word address from latched addr.
- dmem_wdata_o  out  32  write word.
- dmem_rdata_i  in  32  read word, valid RD_LAT cycles after an enabled read edge.

Behaviour:
- Reset: state IDLE; ack_o, err_o, dmem_en_o, dmem_we_o = 0; rdata_o, latched regs and merge reg = 0.
- dmem_* outputs are combinational decodes of state plus latched registers.
- Reset mid-operation:
  - A write whose WRITE cycle coincides with rst is still sampled by memory at that edge.
  - No further access is issued; the request is dropped with no ack.
- States:
  - IDLE: when req_i=1, latch instr_i, addr_i and wdata_i.
    - Illegal op (instr_i not exactly one-hot) -> DONE with err=1, no memory access.
    - Misaligned (see Optional Feature) -> DONE with err=1, no memory access.
    - lb/lbu/lh/lhu/lw/sb/sh -> READ.
    - sw -> WRITE.
  - READ: dmem_en_o=1, dmem_we_o=0; load cnt=RD_LAT; go to WAIT.
  - WAIT: decrement cnt each cycle. In the cycle cnt==1, dmem_rdata_i is valid; then:
    - Loads: rdata_o <= extracted value; go to DONE.
    - sb/sh: merge_q <= merged word; go to WRITE.
  - WRITE: dmem_en_o=1, dmem_we_o=1.
    - dmem_wdata_o = merge_q for sb/sh, latched wdata for sw.
    - Go to DONE.
  - DONE: ack_o=1, err_o valid; go to IDLE. A new req is only sampled in IDLE, so there is one cycle minimum between accepts.
- Extraction, with a = addr[1:0]:
  - lb/lbu: byte a, sign- or zero-extended.
  - lh/lhu: half a[1], sign- or zero-extended.
  - lw: whole word.
- Merge, with d = dmem word and r = wdata:
  - sb: byte lane a replaced by r[7:0]; other bytes of d preserved.
  - sh: half lane a[1] replaced by r[15:0]; other half of d preserved.
- Stores leave rdata_o unchanged. err=0 on every successful access.
- Latency from req_i first high in IDLE to the ack_o cycle, with RD_LAT=1:
  - sw: 3 cycles.
  - Loads: 4 cycles.
  - sb/sh: 5 cycles.
  - Each additional RD_LAT cycle adds 1 to loads and sb/sh.
- req_i deasserting before ack_o (protocol violation): the access still completes and acks.

Optional Feature:
- Macro: DMEM_ALIGN_TRAP_EN.
- Defined:
  - lh/lhu/sh with addr[0]=1 is misaligned.
  - lw/sw with addr[1:0]!=0 is misaligned.
  - A misaligned access goes IDLE->DONE with err_o=1, issues no dmem access, and leaves rdata_o unchanged.
- Undefined:
  - No alignment check.
  - Halfword ops use addr[1] only; word ops ignore addr[1:0].
  - err_o asserts only for illegal op codes.

Test Plan:
- Reset, then sw: addr=0x10, wdata=0xDEADBEEF -> dmem_we_o=1 at word 4 exactly once; ack_o in cycle 3; stall_o high in cycles 1-2 only.
- Preload word 4=0x8899AABB; lb at addr 0x12 -> rdata_o=0xFFFFFF99, ack in cycle 4; lbu at 0x13 -> 0x00000088; lhu at 0x12 -> 0x00008899; lh at 0x10 -> 0xFFFFAABB.
- Word 4=0x11223344; sb at addr 0x11 with wdata=0x000000EE -> one read, then write of 0x1122EE44; ack in cycle 5; readback lw=0x1122EE44.
- Word 4=0x11223344; sh at addr 0x12 with wdata=0x0000CAFE -> write of 0xCAFE3344. Repeat with RD_LAT=3 -> ack in cycle 7.
- instr_i=0x00 and instr_i=0x30 -> err_o=1 with ack in cycle 2, no dmem_en_o. With DMEM_ALIGN_TRAP_EN, lw at 0x11 -> err_o=1 with no access; without it, the same lw returns word 4.
- Assert rst in the WAIT cycle of an sb -> no write occurs, no ack, state IDLE. A following sw completes normally.
